// File: rtl/dmem_rsp.sv
// dmem_rsp: single-port data-memory responder for the core's load/store port.
// One request at a time, programmable wait states, byte-lane merged stores,
// right-aligned zero-filled load data, one-cycle response strobe.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | ready for a request; accept latches the request
// S_WAIT | counting down wait states; array touched on exit
// S_RESP | rsp_valid_o high for this single cycle
module dmem_rsp #(
   parameter int DEPTH_WORDS = 4096,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [1:0]  req_size_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;

   logic        accept;
   logic        enter_resp;
   logic        cur_we;
   logic [31:0] cur_addr;
   logic [1:0]  cur_size;
   logic [31:0] cur_wdata;
   logic        cur_err;
   logic        in_err;
   logic [IDX_W-1:0] cur_idx;
   logic        mem_we;
   logic [3:0]  be;
   logic [31:0] wlanes;
   logic [31:0] rd_word;
   logic [31:0] rd_shift;
   logic [31:0] rd_masked;

   logic [31:0] mem [DEPTH_WORDS];

   assign req_ready_o = (state_q == S_IDLE) && !rst;
   assign accept      = req_valid_i && req_ready_o;

   // With zero wait states the array is accessed on the accept edge itself,
   // so the live inputs are used in IDLE and the latched copy afterwards.
   always_comb begin
      in_err = 1'b0;
      case (req_size_i)
         2'b01:   in_err = req_addr_i[0];
         2'b10:   in_err = (req_addr_i[1:0] != 2'b00);
         2'b11:   in_err = 1'b1;
         default: in_err = 1'b0;
      endcase
      if (req_addr_i[31:2] >= DEPTH_W) in_err = 1'b1;

      if (state_q == S_IDLE) begin
         cur_we    = req_we_i;
         cur_addr  = req_addr_i;
         cur_size  = req_size_i;
         cur_wdata = req_wdata_i;
         cur_err   = in_err;
      end else begin
         cur_we    = we_q;
         cur_addr  = addr_q;
         cur_size  = size_q;
         cur_wdata = wdata_q;
         cur_err   = err_q;
      end
      cur_idx = cur_addr[IDX_W+1:2];
   end

   // Next-state, wait counter, request latch and registered response values.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      size_d      = size_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      enter_resp  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               we_d    = req_we_i;
               addr_d  = req_addr_i;
               size_d  = req_size_i;
               wdata_d = req_wdata_i;
               err_d   = in_err;
               if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end else begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      rsp_valid_d = enter_resp;
      rsp_err_d   = enter_resp && cur_err;
      rsp_rdata_d = (enter_resp && !cur_err && !cur_we) ? rd_masked : 32'h0;
   end

   // Byte enables and lane-replicated store data; load alignment and masking.
   always_comb begin
      case (cur_size)
         2'b00:   be = 4'b0001 << cur_addr[1:0];
         2'b01:   be = cur_addr[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      case (cur_size)
         2'b00:   wlanes = {4{cur_wdata[7:0]}};
         2'b01:   wlanes = {2{cur_wdata[15:0]}};
         default: wlanes = cur_wdata;
      endcase
      mem_we   = enter_resp && cur_we && !cur_err;
      rd_word  = cur_err ? 32'h0 : mem[cur_idx];
      rd_shift = rd_word >> {cur_addr[1:0], 3'b000};
      case (cur_size)
         2'b00:   rd_masked = {24'h0, rd_shift[7:0]};
         2'b01:   rd_masked = {16'h0, rd_shift[15:0]};
         default: rd_masked = rd_shift;
      endcase
   end

   // Array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[cur_idx][8*b +: 8] <= wlanes[8*b +: 8];
         end
      end
   end

   // Control and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         addr_q      <= 32'h0;
         size_q      <= 2'b00;
         wdata_q     <= 32'h0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_rsp.sv
// Bench for dmem_rsp: three instances with 1, 3 and 0 wait states.
module tb_dmem_rsp;

   logic        clk = 1'b0;
   logic        rst [3];
   logic        req_valid [3];
   logic        ready [3];
   logic        we [3];
   logic [31:0] addr [3];
   logic [1:0]  size [3];
   logic [31:0] wdata [3];
   logic        rsp_valid [3];
   logic [31:0] rdata [3];
   logic        rsp_err [3];

   int wc [3] = '{1, 3, 0};
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_rsp #(.DEPTH_WORDS(4096), .WAIT_CYCLES(1)) u0 (
      .clk(clk), .rst(rst[0]), .req_valid_i(req_valid[0]), .req_ready_o(ready[0]),
      .req_we_i(we[0]), .req_addr_i(addr[0]), .req_size_i(size[0]), .req_wdata_i(wdata[0]),
      .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rdata[0]), .rsp_err_o(rsp_err[0]));

   dmem_rsp #(.DEPTH_WORDS(4096), .WAIT_CYCLES(3)) u1 (
      .clk(clk), .rst(rst[1]), .req_valid_i(req_valid[1]), .req_ready_o(ready[1]),
      .req_we_i(we[1]), .req_addr_i(addr[1]), .req_size_i(size[1]), .req_wdata_i(wdata[1]),
      .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rdata[1]), .rsp_err_o(rsp_err[1]));

   dmem_rsp #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0)) u2 (
      .clk(clk), .rst(rst[2]), .req_valid_i(req_valid[2]), .req_ready_o(ready[2]),
      .req_we_i(we[2]), .req_addr_i(addr[2]), .req_size_i(size[2]), .req_wdata_i(wdata[2]),
      .rsp_valid_o(rsp_valid[2]), .rsp_rdata_o(rdata[2]), .rsp_err_o(rsp_err[2]));

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One request through instance d: wait for ready, accept, scramble the
   // inputs, then check latency, response contents and single-cycle strobe.
   task automatic run_req(input int d, input logic w, input logic [31:0] a,
                          input logic [1:0] s, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input string nm);
      int n;
      @(negedge clk);
      req_valid[d] = 1'b1; we[d] = w; addr[d] = a; size[d] = s; wdata[d] = wd;
      n = 0;
      while (!ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready[d]) begin
         chk({nm, " accept timeout"}, 32'd0, 32'd1);
         req_valid[d] = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid[d] = 1'b0;
      we[d]    = ~w;
      addr[d]  = $urandom;
      size[d]  = 2'($urandom_range(0, 3));
      wdata[d] = $urandom;
      n = 1;
      while (!rsp_valid[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({nm, " latency"}, 32'(n), 32'(wc[d] + 1));
      chk({nm, " err"}, {31'h0, rsp_err[d]}, {31'h0, exp_err});
      chk({nm, " rdata"}, rdata[d], exp_rd);
      @(negedge clk);
      chk({nm, " strobe width"}, {31'h0, rsp_valid[d]}, 32'h0);
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; req_valid[i] = 1'b0; we[i] = 1'b0;
         addr[i] = 32'h0; size[i] = 2'b00; wdata[i] = 32'h0;
      end

      // Reset state.
      repeat (2) @(negedge clk);
      chk("reset ready", {31'h0, ready[0]}, 32'h0);
      chk("reset valid", {31'h0, rsp_valid[0]}, 32'h0);
      chk("reset err", {31'h0, rsp_err[0]}, 32'h0);
      chk("reset rdata", rdata[0], 32'h0);
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      #1;
      chk("ready after reset", {31'h0, ready[0]}, 32'h1);

      // Directed vectors on the one-wait-state instance.
      tbl.push_back('{1'b1, 32'h10,   2'b10, 32'hDEADBEEF, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h10,   2'b10, 32'h0,        32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b1, 32'h11,   2'b00, 32'hFFFFFFA5, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h10,   2'b10, 32'h0,        32'hDEADA5EF, 1'b0});
      tbl.push_back('{1'b0, 32'h13,   2'b00, 32'h0,        32'h000000DE, 1'b0});
      tbl.push_back('{1'b0, 32'h12,   2'b01, 32'h0,        32'h0000DEAD, 1'b0});
      tbl.push_back('{1'b0, 32'h11,   2'b01, 32'h0,        32'h0,        1'b1});
      tbl.push_back('{1'b1, 32'h12,   2'b10, 32'h12345678, 32'h0,        1'b1});
      tbl.push_back('{1'b0, 32'h10,   2'b10, 32'h0,        32'hDEADA5EF, 1'b0});
      tbl.push_back('{1'b0, 32'h10,   2'b11, 32'h0,        32'h0,        1'b1});
      tbl.push_back('{1'b0, 32'h4000, 2'b10, 32'h0,        32'h0,        1'b1});
      tbl.push_back('{1'b1, 32'h3FFC, 2'b10, 32'hCAFEF00D, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h3FFC, 2'b10, 32'h0,        32'hCAFEF00D, 1'b0});
      tbl.push_back('{1'b1, 32'h14,   2'b10, 32'h0,        32'h0,        1'b0});
      tbl.push_back('{1'b1, 32'h16,   2'b01, 32'hFFFF1234, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 32'h14,   2'b00, 32'hFFFFFF77, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h14,   2'b10, 32'h0,        32'h12340077, 1'b0});
      tbl.push_back('{1'b0, 32'h17,   2'b00, 32'h0,        32'h00000012, 1'b0});
      tbl.push_back('{1'b0, 32'h14,   2'b01, 32'h0,        32'h00000077, 1'b0});
      tbl.push_back('{1'b0, 32'h15,   2'b00, 32'h0,        32'h00000000, 1'b0});
      foreach (tbl[i]) begin
         run_req(0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].wdata,
                 tbl[i].exp_rd, tbl[i].exp_err, $sformatf("vec%0d", i));
      end

      // Reset during WAIT drops a pending store (three wait states).
      run_req(1, 1'b1, 32'h20, 2'b10, 32'h0, 32'h0, 1'b0, "init 0x20");
      @(negedge clk);
      req_valid[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; size[1] = 2'b10;
      wdata[1] = 32'h11111111;
      chk("rst seq ready before accept", {31'h0, ready[1]}, 32'h1);
      @(negedge clk);
      req_valid[1] = 1'b0;
      chk("rst seq ready in wait", {31'h0, ready[1]}, 32'h0);
      rst[1] = 1'b1;
      #1;
      chk("rst seq ready during rst", {31'h0, ready[1]}, 32'h0);
      seen = 0;
      @(negedge clk);
      rst[1] = 1'b0;
      #1;
      chk("rst seq ready after release", {31'h0, ready[1]}, 32'h1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rsp_valid[1]) seen++;
      end
      chk("rst seq no response", 32'(seen), 32'h0);
      run_req(1, 1'b0, 32'h20, 2'b10, 32'h0, 32'h0, 1'b0, "load 0x20 after rst");

      // Back-to-back loads with req_valid held, zero wait states.
      for (int i = 0; i < 4; i++) begin
         run_req(2, 1'b1, 32'h40 + 32'(4*i), 2'b10, 32'hA0000000 + 32'(i),
                 32'h0, 1'b0, $sformatf("b2b init%0d", i));
      end
      we[2] = 1'b0; size[2] = 2'b10; wdata[2] = 32'h0;
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) addr[2] = 32'h40 + 32'(4*(k/2));
         req_valid[2] = 1'b1;
         #1;
         chk($sformatf("b2b ready c%0d", k), {31'h0, ready[2]}, (k % 2 == 0) ? 32'h1 : 32'h0);
         chk($sformatf("b2b valid c%0d", k), {31'h0, rsp_valid[2]}, (k % 2 == 1) ? 32'h1 : 32'h0);
         if (k % 2 == 1)
            chk($sformatf("b2b rdata c%0d", k), rdata[2], 32'hA0000000 + 32'((k-1)/2));
         @(negedge clk);
      end
      req_valid[2] = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
